router_fsm_nport: RTL and testbench
===================================

Name: router_fsm_nport

Overview:
Parametrised control FSM for the router's packet-input path: the next generation of the fixed 1x3 router FSM, generalised to NUM_PORTS output FIFOs. It decodes the header address and sequences header, payload and parity writes into the selected FIFO. It handles FIFO-full stalls, per-port soft reset and busy-FIFO waits. Addresses beyond NUM_PORTS-1 send the packet to a drop state, which the 1x3 version cannot do.

Parameters:
NUM_PORTS, 3, number of destination FIFOs (2..8).
ADDR_W, 2, header address field width; 2**ADDR_W >= NUM_PORTS is required, and the RTL raises an elaboration error otherwise.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  source asserts while packet bytes are presented
data_in  in  ADDR_W  address field of the header byte
parity_done  in  1  parity byte has been written
low_pkt_valid  in  1  registered pkt_valid from the register block
fifo_full  in  1  full flag of the currently selected FIFO
fifo_empty  in  NUM_PORTS  per-FIFO empty flags
soft_reset  in  NUM_PORTS  per-FIFO soft-reset (read-timeout) requests
busy  out  1  stall request to the source
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
write_en_reg  out  1  write strobe to the register/FIFO path
rst_int_reg  out  1  in CHECK_PARITY_ERROR
dest_port  out  ADDR_W  latched destination index
addr_err  out  1  one-cycle pulse on entry to DROP_PACKET

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY, DROP_PACKET. The state is a register; all outputs except dest_port and addr_err decode from the current state only (Moore).
- Reset (resetn=0, asynchronous): state=DECODE_ADDRESS, dest_port=0, addr_err=0. Therefore detect_add=1 and every other output is 0 during reset. Reset mid-packet aborts immediately; no write strobe follows.
- DECODE_ADDRESS, when pkt_valid=1:
  - dest_port<=data_in is latched.
  - data_in>=NUM_PORTS -> DROP_PACKET, with addr_err=1 on the next cycle only.
  - fifo_empty[data_in]=1 -> LOAD_FIRST_DATA.
  - otherwise -> WAIT_TILL_EMPTY.
  - pkt_valid=0 -> stay; dest_port holds.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full has priority over !pkt_valid.
- FIFO_FULL_STATE: stays while fifo_full; -> LOAD_AFTER_FULL when it clears.
- LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_DATA; else -> LOAD_PARITY.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty[dest_port] -> LOAD_FIRST_DATA; else stay.
- DROP_PACKET: stays while pkt_valid=1; -> DECODE_ADDRESS when pkt_valid=0.
- Soft reset: soft_reset[dest_port]=1 in any state other than DECODE_ADDRESS and DROP_PACKET forces DECODE_ADDRESS next cycle. This overrides all other transitions. soft_reset of a non-selected port is ignored.
- busy=1 in LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR and WAIT_TILL_EMPTY. busy=0 in DECODE_ADDRESS, LOAD_DATA and DROP_PACKET, so the source drains a dropped packet at full rate.
- write_en_reg=1 in LOAD_DATA, LOAD_AFTER_FULL and LOAD_PARITY; 0 elsewhere. It is never asserted in DROP_PACKET.
- dest_port changes only in DECODE_ADDRESS with pkt_valid=1.
- fifo_empty index into a dest_port >= NUM_PORTS is never evaluated, because those addresses always go to DROP_PACKET.

Test Plan:
1. NUM_PORTS=3. data_in=1, fifo_empty[1]=1, pkt_valid high 3 cycles then low -> states DECODE->LFD->LD->LD->LP->CPE->DECODE; dest_port=1; write_en_reg high 3 cycles; rst_int_reg high 1 cycle.
2. Same packet with fifo_full=1 for 2 cycles in LD -> FULL for 2 cycles with busy=1 -> LAF. Then parity_done=0, low_pkt_valid=1 -> LD; and parity_done=0, low_pkt_valid=0 -> LP.
3. NUM_PORTS=3, data_in=3, pkt_valid high 4 cycles -> DROP_PACKET; addr_err single pulse; busy=0; write_en_reg=0 throughout; DECODE one cycle after pkt_valid falls.
4. data_in=2, fifo_empty[2]=0 -> WAIT_TILL_EMPTY with busy=1. Pulse soft_reset[0] -> no change. Pulse soft_reset[2] -> DECODE next cycle.
5. NUM_PORTS=5, ADDR_W=3, data_in=4, fifo_empty[4]=1 -> LFD, dest_port=4. data_in=5 -> DROP with addr_err.
6. resetn low mid-LD (asynchronous, between edges) -> detect_add=1 and write_en_reg=0 immediately; dest_port=0.

Source files
------------

// File: rtl/router_fsm_nport.sv
`default_nettype none
// ============================================================================
//  Module      : router_fsm_nport
//  Description : Control FSM for the router packet-input path, generalised to
//                NUM_PORTS destination FIFOs. Decodes the header address,
//                sequences header/payload/parity writes into the selected
//                FIFO, handles FIFO-full stalls, per-port soft reset, waits
//                for a busy FIFO to drain, and drops packets that are
//                addressed to a port that does not exist.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   rising-edge clock
//    resetn         in   asynchronous active-low reset
//    pkt_valid      in   source presents packet bytes
//    data_in        in   header address field (ADDR_W)
//    parity_done    in   parity byte has been written
//    low_pkt_valid  in   registered pkt_valid from the register block
//    fifo_full      in   full flag of the selected FIFO
//    fifo_empty     in   per-FIFO empty flags (NUM_PORTS)
//    soft_reset     in   per-FIFO soft-reset requests (NUM_PORTS)
//    busy           out  stall request to the source
//    detect_add     out  state is DECODE_ADDRESS
//    lfd_state      out  state is LOAD_FIRST_DATA
//    ld_state       out  state is LOAD_DATA
//    laf_state      out  state is LOAD_AFTER_FULL
//    full_state     out  state is FIFO_FULL_STATE
//    write_en_reg   out  write strobe to the register/FIFO path
//    rst_int_reg    out  state is CHECK_PARITY_ERROR
//    dest_port      out  latched destination index (ADDR_W)
//    addr_err       out  one-cycle pulse on entry to DROP_PACKET
// ============================================================================
module router_fsm_nport #(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic                 parity_done,
   input  logic                 low_pkt_valid,
   input  logic                 fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   output logic                 busy,
   output logic                 detect_add,
   output logic                 lfd_state,
   output logic                 ld_state,
   output logic                 laf_state,
   output logic                 full_state,
   output logic                 write_en_reg,
   output logic                 rst_int_reg,
   output logic [ADDR_W-1:0]    dest_port,
   output logic                 addr_err
);

   // Number of codes the address field can express.
   localparam int c_NUM_ADDR = 1 << ADDR_W;
   // NUM_PORTS one bit wider than the address so the range compare is exact.
   localparam logic [ADDR_W:0] c_NUM_PORTS_EXT = (ADDR_W+1)'(NUM_PORTS);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
      $error("router_fsm_nport: NUM_PORTS must be in 2..8");
   end

   if (c_NUM_ADDR < NUM_PORTS) begin : g_bad_addr_w
      $error("router_fsm_nport: 2**ADDR_W must be >= NUM_PORTS");
   end

   typedef enum logic [3:0] {
      ST_DECODE   = 4'd0,
      ST_LFD      = 4'd1,
      ST_LD       = 4'd2,
      ST_FULL     = 4'd3,
      ST_LAF      = 4'd4,
      ST_LP       = 4'd5,
      ST_CPE      = 4'd6,
      ST_WTE      = 4'd7,
      ST_DROP     = 4'd8
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_dest_port;
   logic              r_addr_err;

   // Per-port flags widened to every address code, so that indexing with a
   // full ADDR_W value never runs off the end. Unused codes read as 0.
   logic [c_NUM_ADDR-1:0] w_empty_pad;
   logic [c_NUM_ADDR-1:0] w_sreset_pad;

   for (genvar gi = 0; gi < c_NUM_ADDR; gi++) begin : g_pad
      if (gi < NUM_PORTS) begin : g_port
         assign w_empty_pad[gi]  = fifo_empty[gi];
         assign w_sreset_pad[gi] = soft_reset[gi];
      end else begin : g_unused
         assign w_empty_pad[gi]  = 1'b0;
         assign w_sreset_pad[gi] = 1'b0;
      end
   end

   logic w_addr_bad;
   logic w_hdr_accept;
   logic w_enter_drop;
   logic w_soft_rst;

   assign w_addr_bad   = ({1'b0, data_in} >= c_NUM_PORTS_EXT);
   assign w_hdr_accept = (r_state == ST_DECODE) && pkt_valid;
   assign w_enter_drop = w_hdr_accept && w_addr_bad;
   // Soft reset only matters while a FIFO is actually owned by this packet.
   assign w_soft_rst   = w_sreset_pad[r_dest_port]
                         && (r_state != ST_DECODE)
                         && (r_state != ST_DROP);

   // ------------------------------------------------------------------------
   // State register, destination latch and drop pulse
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_DECODE;
         r_dest_port <= '0;
         r_addr_err  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_addr_err <= w_enter_drop;
         if (w_hdr_accept) begin
            r_dest_port <= data_in;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_DECODE: begin
            if (pkt_valid) begin
               // Range check first: fifo_empty is never consulted for a
               // nonexistent port.
               if (w_addr_bad) begin
                  w_next = ST_DROP;
               end else if (w_empty_pad[data_in]) begin
                  w_next = ST_LFD;
               end else begin
                  w_next = ST_WTE;
               end
            end
         end
         ST_LFD: begin
            w_next = ST_LD;
         end
         ST_LD: begin
            if (fifo_full) begin
               w_next = ST_FULL;
            end else if (!pkt_valid) begin
               w_next = ST_LP;
            end
         end
         ST_FULL: begin
            if (!fifo_full) begin
               w_next = ST_LAF;
            end
         end
         ST_LAF: begin
            if (parity_done) begin
               w_next = ST_DECODE;
            end else if (low_pkt_valid) begin
               w_next = ST_LD;
            end else begin
               w_next = ST_LP;
            end
         end
         ST_LP: begin
            w_next = ST_CPE;
         end
         ST_CPE: begin
            if (fifo_full) begin
               w_next = ST_FULL;
            end else begin
               w_next = ST_DECODE;
            end
         end
         ST_WTE: begin
            if (w_empty_pad[r_dest_port]) begin
               w_next = ST_LFD;
            end
         end
         ST_DROP: begin
            if (!pkt_valid) begin
               w_next = ST_DECODE;
            end
         end
         default: begin
            w_next = ST_DECODE;
         end
      endcase

      if (w_soft_rst) begin
         w_next = ST_DECODE;
      end
   end

   // ------------------------------------------------------------------------
   // Moore outputs
   // ------------------------------------------------------------------------
   always_comb begin
      busy         = 1'b0;
      detect_add   = 1'b0;
      lfd_state    = 1'b0;
      ld_state     = 1'b0;
      laf_state    = 1'b0;
      full_state   = 1'b0;
      write_en_reg = 1'b0;
      rst_int_reg  = 1'b0;
      case (r_state)
         ST_DECODE: detect_add = 1'b1;
         ST_LFD: begin
            lfd_state = 1'b1;
            busy      = 1'b1;
         end
         ST_LD: begin
            ld_state     = 1'b1;
            write_en_reg = 1'b1;
         end
         ST_FULL: begin
            full_state = 1'b1;
            busy       = 1'b1;
         end
         ST_LAF: begin
            laf_state    = 1'b1;
            busy         = 1'b1;
            write_en_reg = 1'b1;
         end
         ST_LP: begin
            busy         = 1'b1;
            write_en_reg = 1'b1;
         end
         ST_CPE: begin
            rst_int_reg = 1'b1;
            busy        = 1'b1;
         end
         ST_WTE: busy = 1'b1;
         // Dropped packets drain at full rate with no write strobe.
         ST_DROP: busy = 1'b0;
         default: detect_add = 1'b0;
      endcase
   end

   assign dest_port = r_dest_port;
   assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_nport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_fsm_nport
//  Description : Directed self-checking bench for router_fsm_nport. A 3-port
//                and a 5-port instance share clock, reset and the scalar
//                control inputs. Observed state is the packed vector
//                {detect_add,lfd,ld,laf,full,rst_int,busy,write_en}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fsm_nport;

   localparam logic [7:0] S_DA   = 8'b1000_0000;
   localparam logic [7:0] S_LFD  = 8'b0100_0010;
   localparam logic [7:0] S_LD   = 8'b0010_0001;
   localparam logic [7:0] S_LAF  = 8'b0001_0011;
   localparam logic [7:0] S_FULL = 8'b0000_1010;
   localparam logic [7:0] S_LP   = 8'b0000_0011;
   localparam logic [7:0] S_CPE  = 8'b0000_0110;
   localparam logic [7:0] S_WTE  = 8'b0000_0010;
   localparam logic [7:0] S_DROP = 8'b0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   logic       pkt_valid;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       fifo_full;

   logic [1:0] data_in3;
   logic [2:0] fifo_empty3;
   logic [2:0] soft_reset3;
   logic       busy3, da3, lfd3, ld3, laf3, full3, wen3, rst3, ae3;
   logic [1:0] dp3;

   logic [2:0] data_in5;
   logic [4:0] fifo_empty5;
   logic [4:0] soft_reset5;
   logic       busy5, da5, lfd5, ld5, laf5, full5, wen5, rst5, ae5;
   logic [2:0] dp5;

   logic [7:0] obs3;
   logic [7:0] obs5;
   assign obs3 = {da3, lfd3, ld3, laf3, full3, rst3, busy3, wen3};
   assign obs5 = {da5, lfd5, ld5, laf5, full5, rst5, busy5, wen5};

   int errors = 0;
   int checks = 0;

   router_fsm_nport #(.NUM_PORTS(3), .ADDR_W(2)) u_dut3 (
      .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in3),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty3), .soft_reset(soft_reset3),
      .busy(busy3), .detect_add(da3), .lfd_state(lfd3), .ld_state(ld3),
      .laf_state(laf3), .full_state(full3), .write_en_reg(wen3),
      .rst_int_reg(rst3), .dest_port(dp3), .addr_err(ae3)
   );

   router_fsm_nport #(.NUM_PORTS(5), .ADDR_W(3)) u_dut5 (
      .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in5),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty5), .soft_reset(soft_reset5),
      .busy(busy5), .detect_add(da5), .lfd_state(lfd5), .ld_state(ld5),
      .laf_state(laf5), .full_state(full5), .write_en_reg(wen5),
      .rst_int_reg(rst5), .dest_port(dp5), .addr_err(ae5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn        = 1'b0;
      pkt_valid     = 1'b0;
      parity_done   = 1'b0;
      low_pkt_valid = 1'b0;
      fifo_full     = 1'b0;
      data_in3      = '0;
      fifo_empty3   = '0;
      soft_reset3   = '0;
      data_in5      = '0;
      fifo_empty5   = '0;
      soft_reset5   = '0;
      repeat (2) tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn        = 1'b0;
      pkt_valid     = 1'b0;
      parity_done   = 1'b0;
      low_pkt_valid = 1'b0;
      fifo_full     = 1'b0;
      data_in3      = '0;
      fifo_empty3   = '0;
      soft_reset3   = '0;
      data_in5      = '0;
      fifo_empty5   = '0;
      soft_reset5   = '0;
      tick();
      checks++;
      if (obs3 !== S_DA) begin
         errors++;
         $display("FAIL reset_state3 got=%b exp=%b", obs3, S_DA);
      end
      checks++;
      if (obs5 !== S_DA) begin
         errors++;
         $display("FAIL reset_state5 got=%b exp=%b", obs5, S_DA);
      end
      checks++;
      if ({dp3, ae3, dp5, ae5} !== 7'b0) begin
         errors++;
         $display("FAIL reset_dest got=%b exp=0", {dp3, ae3, dp5, ae5});
      end
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_basic_packet();
      logic [7:0] exp [7];
      logic       pv  [7];
      int         wen_cnt;
      int         rst_cnt;
      exp = '{S_DA, S_LFD, S_LD, S_LD, S_LP, S_CPE, S_DA};
      pv  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      wen_cnt = 0;
      rst_cnt = 0;
      do_reset();
      data_in3    = 2'd1;
      fifo_empty3 = 3'b010;
      for (int i = 0; i < 7; i++) begin
         pkt_valid = pv[i];
         checks++;
         if (obs3 !== exp[i]) begin
            errors++;
            $display("FAIL basic_state[%0d] got=%b exp=%b", i, obs3, exp[i]);
         end
         if (wen3 === 1'b1) wen_cnt++;
         if (rst3 === 1'b1) rst_cnt++;
         tick();
      end
      checks++;
      if (dp3 !== 2'd1) begin
         errors++;
         $display("FAIL basic_dest got=%0d exp=1", dp3);
      end
      checks++;
      if (wen_cnt != 3) begin
         errors++;
         $display("FAIL basic_wen_cycles got=%0d exp=3", wen_cnt);
      end
      checks++;
      if (rst_cnt != 1) begin
         errors++;
         $display("FAIL basic_rst_int_cycles got=%0d exp=1", rst_cnt);
      end
   endtask

   task automatic test_fifo_full();
      logic [7:0] exp [14];
      logic       pv  [14];
      logic       ff  [14];
      logic       pd  [14];
      logic       lp  [14];
      exp = '{S_DA, S_LFD, S_LD, S_FULL, S_FULL, S_LAF, S_LD,
              S_FULL, S_LAF, S_LP, S_CPE, S_FULL, S_LAF, S_DA};
      pv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ff  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      pd  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      lp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      data_in3    = 2'd1;
      fifo_empty3 = 3'b010;
      for (int i = 0; i < 14; i++) begin
         pkt_valid     = pv[i];
         fifo_full     = ff[i];
         parity_done   = pd[i];
         low_pkt_valid = lp[i];
         checks++;
         if (obs3 !== exp[i]) begin
            errors++;
            $display("FAIL full_state[%0d] got=%b exp=%b", i, obs3, exp[i]);
         end
         tick();
      end
   endtask

   task automatic test_drop();
      logic [7:0] exp [6];
      logic       pv  [6];
      logic       ae  [6];
      exp = '{S_DA, S_DROP, S_DROP, S_DROP, S_DROP, S_DA};
      pv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      ae  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      data_in3    = 2'd3;
      fifo_empty3 = 3'b111;
      for (int i = 0; i < 6; i++) begin
         pkt_valid = pv[i];
         checks++;
         if (obs3 !== exp[i] || ae3 !== ae[i]) begin
            errors++;
            $display("FAIL drop[%0d] got=%b/ae%b exp=%b/ae%b",
                     i, obs3, ae3, exp[i], ae[i]);
         end
         tick();
      end
      checks++;
      if (dp3 !== 2'd3) begin
         errors++;
         $display("FAIL drop_dest got=%0d exp=3", dp3);
      end
   endtask

   task automatic test_wait_soft_reset();
      logic [7:0] exp [9];
      logic       pv  [9];
      logic [2:0] fe  [9];
      logic [2:0] sr  [9];
      exp = '{S_DA, S_WTE, S_WTE, S_WTE, S_DA, S_WTE, S_LFD, S_DA, S_DA};
      pv  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      fe  = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011,
              3'b100, 3'b100, 3'b100, 3'b100};
      sr  = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b000,
              3'b000, 3'b100, 3'b100, 3'b000};
      do_reset();
      data_in3 = 2'd2;
      for (int i = 0; i < 9; i++) begin
         pkt_valid   = pv[i];
         fifo_empty3 = fe[i];
         soft_reset3 = sr[i];
         checks++;
         if (obs3 !== exp[i]) begin
            errors++;
            $display("FAIL wait_sreset[%0d] got=%b exp=%b", i, obs3, exp[i]);
         end
         tick();
      end
   endtask

   task automatic test_five_ports();
      logic [7:0] exp [8];
      logic       pv  [8];
      logic [2:0] di  [8];
      logic [2:0] dp  [8];
      logic       ae  [8];
      exp = '{S_DA, S_LFD, S_LD, S_LP, S_CPE, S_DA, S_DROP, S_DA};
      pv  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      di  = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5};
      dp  = '{3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5};
      ae  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      fifo_empty5 = 5'b10000;
      for (int i = 0; i < 8; i++) begin
         pkt_valid = pv[i];
         data_in5  = di[i];
         checks++;
         if (obs5 !== exp[i] || dp5 !== dp[i] || ae5 !== ae[i]) begin
            errors++;
            $display("FAIL five_port[%0d] got=%b/dp%0d/ae%b exp=%b/dp%0d/ae%b",
                     i, obs5, dp5, ae5, exp[i], dp[i], ae[i]);
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      data_in3    = 2'd2;
      fifo_empty3 = 3'b100;
      pkt_valid   = 1'b1;
      tick();
      tick();
      checks++;
      if (obs3 !== S_LD || dp3 !== 2'd2) begin
         errors++;
         $display("FAIL async_pre got=%b/dp%0d exp=%b/dp2", obs3, dp3, S_LD);
      end
      #3;
      resetn = 1'b0;
      #1;
      checks++;
      if (obs3 !== S_DA || dp3 !== 2'd0 || ae3 !== 1'b0) begin
         errors++;
         $display("FAIL async_now got=%b/dp%0d/ae%b exp=%b/dp0/ae0",
                  obs3, dp3, ae3, S_DA);
      end
      tick();
      checks++;
      if (obs3 !== S_DA || wen3 !== 1'b0) begin
         errors++;
         $display("FAIL async_hold got=%b exp=%b", obs3, S_DA);
      end
      resetn    = 1'b1;
      pkt_valid = 1'b0;
      tick();
      checks++;
      if (obs3 !== S_DA || dp3 !== 2'd0) begin
         errors++;
         $display("FAIL async_after got=%b/dp%0d exp=%b/dp0", obs3, dp3, S_DA);
      end
   endtask

   initial begin
      test_reset();
      test_basic_packet();
      test_fifo_full();
      test_drop();
      test_wait_soft_reset();
      test_five_ports();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
